// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port RAM.
// Data wins ties until it has won MAX_STREAK times in a row over a waiting fetch.
module riscv_mem_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 128,
  parameter int MAX_STREAK  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [WORD_LENGTH-1:0] i_addr,
  output logic                   i_ready,
  output logic                   i_rvalid,
  output logic [WORD_LENGTH-1:0] i_rdata,
  output logic                   i_err,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [WORD_LENGTH-1:0] d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  output logic                   d_ready,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic                   d_err,
  output logic [WORD_LENGTH-1:0] m_addr,
  output logic                   m_write_en,
  output logic [WORD_LENGTH-1:0] m_wdata,
  input  logic [WORD_LENGTH-1:0] m_rdata
);

  localparam logic MEM_WRITE   = 1'b1;
  localparam logic MEM_NOWRITE = 1'b0;
  localparam logic [1:0] STREAK_LIM = 2'(MAX_STREAK);
  localparam logic [WORD_LENGTH-1:0] ADDR_MAX = WORD_LENGTH'(NUM_MEM - 4);

  function automatic logic addr_fault(input logic [WORD_LENGTH-1:0] a);
    return (a[1:0] != 2'b00) || (a > ADDR_MAX);
  endfunction

  logic [1:0]             r_streak;
  logic                   w_grant_i_p0;
  logic                   w_grant_d_p0;
  logic                   w_fault_i_p0;
  logic                   w_fault_d_p0;
  logic                   r_i_vld_p1;
  logic                   r_i_err_p1;
  logic [WORD_LENGTH-1:0] r_i_rdata_p1;
  logic                   r_d_vld_p1;
  logic                   r_d_err_p1;
  logic [WORD_LENGTH-1:0] r_d_rdata_p1;

  // Stage p0: grant selection and RAM drive, all in the request cycle
  always_comb begin
    w_grant_d_p0 = 1'b0;
    w_grant_i_p0 = 1'b0;
    if (!rst) begin
      w_grant_d_p0 = d_req && !(i_req && (r_streak == STREAK_LIM));
      w_grant_i_p0 = i_req && !w_grant_d_p0;
    end
  end

  assign w_fault_i_p0 = addr_fault(i_addr);
  assign w_fault_d_p0 = addr_fault(d_addr);

  assign i_ready    = w_grant_i_p0;
  assign d_ready    = w_grant_d_p0;
  assign m_addr     = w_grant_d_p0 ? d_addr : i_addr;
  assign m_wdata    = (w_grant_d_p0 && d_we) ? d_wdata : '0;
  assign m_write_en = (w_grant_d_p0 && d_we && !w_fault_d_p0) ? MEM_WRITE : MEM_NOWRITE;

  // Streak only counts data wins that actually held off a pending fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= 2'd0;
    end else if (!i_req || w_grant_i_p0) begin
      r_streak <= 2'd0;
    end else if (w_grant_d_p0 && (r_streak != 2'b11)) begin
      r_streak <= r_streak + 2'd1;
    end
  end

  // Stage p1: response registered at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_vld_p1   <= 1'b0;
      r_i_err_p1   <= 1'b0;
      r_i_rdata_p1 <= '0;
      r_d_vld_p1   <= 1'b0;
      r_d_err_p1   <= 1'b0;
      r_d_rdata_p1 <= '0;
    end else begin
      r_i_vld_p1 <= w_grant_i_p0;
      r_i_err_p1 <= w_grant_i_p0 && w_fault_i_p0;
      if (w_grant_i_p0 && !w_fault_i_p0) begin
        r_i_rdata_p1 <= m_rdata;
      end
      r_d_vld_p1 <= w_grant_d_p0;
      r_d_err_p1 <= w_grant_d_p0 && w_fault_d_p0;
      if (w_grant_d_p0 && !d_we && !w_fault_d_p0) begin
        r_d_rdata_p1 <= m_rdata;
      end
    end
  end

  // A response still in flight when reset rises is suppressed immediately
  assign i_rvalid = r_i_vld_p1 && !rst;
  assign i_err    = r_i_err_p1 && !rst;
  assign i_rdata  = r_i_rdata_p1;
  assign d_rvalid = r_d_vld_p1 && !rst;
  assign d_err    = r_d_err_p1 && !rst;
  assign d_rdata  = r_d_rdata_p1;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a byte RAM model and response scoreboard.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ready, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_write_en;

  int n_tests = 0;
  int n_fail  = 0;
  logic no_push = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t iq[$];
  rsp_t dq[$];

  logic [7:0] mem [0:127];

  riscv_mem_arbiter #(.WORD_LENGTH(32), .NUM_MEM(128), .MAX_STREAK(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_addr(m_addr), .m_write_en(m_write_en), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Little-endian combinational read, byte-wise write on the clock
  always_comb begin
    m_rdata = 32'h0;
    if (m_addr <= 32'd124)
      m_rdata = {mem[int'(m_addr)+3], mem[int'(m_addr)+2], mem[int'(m_addr)+1], mem[int'(m_addr)]};
  end

  always @(posedge clk) begin
    if (m_write_en === 1'b1 && m_addr <= 32'd124) begin
      mem[int'(m_addr)]   <= m_wdata[7:0];
      mem[int'(m_addr)+1] <= m_wdata[15:8];
      mem[int'(m_addr)+2] <= m_wdata[23:16];
      mem[int'(m_addr)+3] <= m_wdata[31:24];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_word(input int a, input logic [31:0] w);
    mem[a] = w[7:0]; mem[a+1] = w[15:8]; mem[a+2] = w[23:16]; mem[a+3] = w[31:24];
  endtask

  task automatic set_i(input logic req, input logic [31:0] a);
    i_req = req; i_addr = a;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  // One clock: check grant/write-enable, queue expected responses for accepted requests
  task automatic step(input logic e_ir, input logic e_dr, input logic e_we,
                      input logic [31:0] ei, input logic eie,
                      input logic [31:0] ed, input logic ede);
    rsp_t r;
    @(negedge clk);
    check("i_ready", {31'b0, i_ready}, {31'b0, e_ir});
    check("d_ready", {31'b0, d_ready}, {31'b0, e_dr});
    check("m_write_en", {31'b0, m_write_en}, {31'b0, e_we});
    if (e_ir && !no_push) begin r.rdata = ei; r.err = eie; iq.push_back(r); end
    if (e_dr && !no_push) begin r.rdata = ed; r.err = ede; dq.push_back(r); end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    rsp_t e;
    if (i_rvalid === 1'b1) begin
      if (iq.size() == 0) begin
        check("i_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = iq.pop_front();
        check("i_err", {31'b0, i_err}, {31'b0, e.err});
        if (!e.err) check("i_rdata", i_rdata, e.rdata);
      end
    end
    if (d_rvalid === 1'b1) begin
      if (dq.size() == 0) begin
        check("d_unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = dq.pop_front();
        check("d_err", {31'b0, d_err}, {31'b0, e.err});
        if (!e.err) check("d_rdata", d_rdata, e.rdata);
      end
    end
  end

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 8'h00;
    load_word(0,    32'h00100193);
    load_word(4,    32'h00200213);
    load_word(8,    32'h00300293);
    load_word(16,   32'hCAFEF00D);
    load_word(124,  32'h55AA55AA);

    // Reset with both requesters active: nothing granted, nothing written
    rst = 1'b1;
    set_i(1'b1, 32'h0);
    set_d(1'b1, 1'b1, 32'h10, 32'h00000BAD);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    check("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_i(1'b0, 32'h20);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("idle_m_addr", m_addr, 32'h20);
    @(posedge clk); #1;

    // Single fetch
    set_i(1'b1, 32'h0);
    step(1, 0, 0, 32'h00100193, 0, 0, 0);
    set_i(1'b0, 32'h0);

    // Store then load back; store acks leave d_rdata untouched
    set_d(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    step(0, 1, 1, 0, 0, 32'h00000000, 0);
    set_d(1'b1, 1'b0, 32'h40, 32'h0);
    step(0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
    set_d(1'b1, 1'b1, 32'h44, 32'h01020304);
    step(0, 1, 1, 0, 0, 32'hDEADBEEF, 0);
    set_d(1'b1, 1'b0, 32'h44, 32'h0);
    step(0, 1, 0, 0, 0, 32'h01020304, 0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Contention: D,D,I,D,D,I
    set_i(1'b1, 32'h4);
    set_d(1'b1, 1'b0, 32'h10, 32'h0);
    step(0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
    step(0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
    step(1, 0, 0, 32'h00200213, 0, 0, 0);
    step(0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
    step(0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
    step(1, 0, 0, 32'h00200213, 0, 0, 0);
    set_i(1'b0, 32'h0);

    // Faults: misaligned, past end, faulting store, misaligned fetch
    set_d(1'b1, 1'b0, 32'h42, 32'h0);
    step(0, 1, 0, 0, 0, 0, 1);
    set_d(1'b1, 1'b0, 32'h7D, 32'h0);
    step(0, 1, 0, 0, 0, 0, 1);
    set_d(1'b1, 1'b1, 32'h7D, 32'h12345678);
    step(0, 1, 0, 0, 0, 0, 1);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    set_i(1'b1, 32'h2);
    step(1, 0, 0, 0, 1, 0, 0);
    set_i(1'b0, 32'h0);

    // Last legal word, then a load whose address changes after acceptance
    set_d(1'b1, 1'b0, 32'h7C, 32'h0);
    step(0, 1, 0, 0, 0, 32'h55AA55AA, 0);
    set_d(1'b1, 1'b0, 32'h10, 32'h0);
    step(0, 1, 0, 0, 0, 32'hCAFEF00D, 0);
    set_d(1'b0, 1'b1, 32'h7C, 32'hFFFFFFFF);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset in the response cycle drops the fetch; later fetch is normal
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    set_i(1'b1, 32'h8);
    no_push = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    no_push = 1'b0;
    set_i(1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drop_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    set_i(1'b1, 32'h8);
    step(1, 0, 0, 32'h00300293, 0, 0, 0);
    set_i(1'b0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    check("i_queue_drained", iq.size(), 32'd0);
    check("d_queue_drained", dq.size(), 32'd0);
    check("mem_0x40", {mem[67], mem[66], mem[65], mem[64]}, 32'hDEADBEEF);
    check("mem_0x10_untouched", {mem[19], mem[18], mem[17], mem[16]}, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
